// File: rtl/dual_input_debouncer.sv
// Two-channel 2-flop synchroniser plus stability-count debouncer for raw switch inputs.
// Optional rising-edge pulse outputs are built when DEBOUNCE_EDGE_EN is defined.
module dual_input_debouncer #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
`ifdef DEBOUNCE_EDGE_EN
  output logic a_rise,
  output logic b_rise,
`endif
  output logic settled
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // bit 0 is channel A, bit 1 is channel B
  logic [1:0]       raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       out_q, out_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  assign raw = {b_raw, a_raw};

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != out_q[i]) begin
        if (cnt_q[i] == CNT_LAST) out_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] rise_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= '0;
`endif
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
`ifdef DEBOUNCE_EDGE_EN
      // pulse lands in the same cycle the output first reads 1
      rise_q  <= out_d & ~out_q;
`endif
    end
  end

  assign a       = out_q[0];
  assign b       = out_q[1];
  assign settled = (sync2_q == out_q);

`ifdef DEBOUNCE_EDGE_EN
  assign a_rise = rise_q[0];
  assign b_rise = rise_q[1];
`endif

endmodule

// File: tb/tb_dual_input_debouncer.sv
// Scoreboarded bench for dual_input_debouncer with STABLE_CYCLES=4, plus directed latency checks.
module tb_dual_input_debouncer;
  localparam int SC = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, settled;
`ifdef DEBOUNCE_EDGE_EN
  logic a_rise, b_rise;
`endif

  int total = 0;
  int bad   = 0;

  dual_input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_raw   (a_raw),
    .b_raw   (b_raw),
    .a       (a),
    .b       (b),
`ifdef DEBOUNCE_EDGE_EN
    .a_rise  (a_rise),
    .b_rise  (b_rise),
`endif
    .settled (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced once per rising edge; expectations queued then compared 1ns later.
  logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_out = 2'b00, m_rise = 2'b00, m_old;
  int         m_run [2] = '{0, 0};
  logic [4:0] exp_q [$];

  always @(posedge clk) begin
    logic [4:0] e, g;
    m_old = m_out;
    if (rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_out = 2'b00; m_rise = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_out[i]) m_run[i] = 0;
        else if (m_run[i] == SC - 1) begin
          m_out[i] = m_s2[i];
          m_run[i] = 0;
        end else m_run[i]++;
      end
      m_rise = m_out & ~m_old;
      m_s2 = m_s1;
      m_s1 = {b_raw, a_raw};
    end
    exp_q.push_back({m_out[0], m_out[1], (m_s2 == m_out), m_rise[0], m_rise[1]});
    #1;
    e = exp_q.pop_front();
`ifdef DEBOUNCE_EDGE_EN
    g = {a, b, settled, a_rise, b_rise};
    check("sb_abs_rise", int'(g), int'(e));
`else
    g = {a, b, settled, 2'b00};
    check("sb_abs", int'(g[4:2]), int'(e[4:2]));
`endif
  end

  task automatic drive(input logic ra, input logic rb);
    @(negedge clk);
    a_raw = ra;
    b_raw = rb;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts edges (the first edge after the drive is 1) until `a` reads 1; returns 99 on timeout.
  task automatic edges_to_a_high(output int n, output int settled_mid);
    n = 99;
    settled_mid = 1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      if (k == 3) settled_mid = int'(settled);
      if (a) begin n = k; break; end
    end
  endtask

  initial begin
    int n, smid, trans, bseen;
    logic prev_a;

    // reset held with raw inputs high
    rst = 1'b1; a_raw = 1'b1; b_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check("rst_a", int'(a), 0);
      check("rst_b", int'(b), 0);
      check("rst_settled", int'(settled), 1);
    end
    @(negedge clk);
    rst = 1'b0; a_raw = 1'b0; b_raw = 1'b0;
    idle(4);

    // clean rise on A
    drive(1'b1, 1'b0);
    edges_to_a_high(n, smid);
    check("clean_latency", n, 6);
    check("clean_settled_low", smid, 0);
    check("clean_b_low", int'(b), 0);
    check("clean_settled_after", int'(settled), 1);
    drive(1'b0, 1'b0);
    idle(10);
    check("clean_fall_a", int'(a), 0);

    // glitch on B
    bseen = 0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      if (b) bseen = 1;
    end
    check("glitch_b_never", bseen, 0);
    check("glitch_settled", int'(settled), 1);

    // bounce on A, then hold high
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    trans = 0; prev_a = a; n = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      if (a != prev_a) trans++;
      if (a && n == 99) n = k;
      prev_a = a;
    end
    check("bounce_latency", n, 6);
    check("bounce_transitions", trans, 1);
    drive(1'b0, 1'b0);
    idle(10);

    // both channels together, downstream AND
    drive(1'b1, 1'b1);
    edges_to_a_high(n, smid);
    check("both_latency", n, 6);
    check("both_b_same_edge", int'(b), 1);
    check("both_and", int'(a & b), 1);
`ifdef DEBOUNCE_EDGE_EN
    check("both_rise_pulse", int'({a_rise, b_rise}), 3);
    @(posedge clk); #2;
    check("both_rise_one_cycle", int'({a_rise, b_rise}), 0);
`endif
    drive(1'b0, 1'b0);
    idle(10);
`ifdef DEBOUNCE_EDGE_EN
    check("fall_no_pulse", int'({a_rise, b_rise}), 0);
`endif

    // reset mid-count, then full recount
    drive(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    check("midrst_a", int'(a), 0);
    check("midrst_settled", int'(settled), 1);
    @(negedge clk); rst = 1'b0;
    edges_to_a_high(n, smid);
    check("midrst_recount", n, 6);

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/dual_input_debouncer.md
Name: dual_input_debouncer

Overview:
- Two-channel synchroniser and debouncer that sits directly upstream of the two-input gate blocks.
- Converts asynchronous, bouncy raw inputs (switches/buttons) into clean, clock-aligned `a` and `b` levels that drive the gate's `a`/`b` inputs.
- Each channel accepts a new level only after the synchronised raw input has held that level for STABLE_CYCLES consecutive clocks.
- A `settled` flag tells downstream logic and benches when both levels are trustworthy.

Parameters:
- STABLE_CYCLES, 1000: consecutive clocks a changed synchronised input must hold before the output follows. Legal range 1 .. 2^CNT_W - 1.
- CNT_W, 16: width of each channel's stability counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- a_raw  input  1  asynchronous raw input, channel A.
- b_raw  input  1  asynchronous raw input, channel B.
- a  output  1  debounced level, channel A; feeds gate input `a`.
- b  output  1  debounced level, channel B; feeds gate input `b`.
- settled  output  1  high when both channels have no pending change.

Interface decision:
- One clock, `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset: while `rst` is high at a rising edge, all of the following clear to 0: sync1, sync2, counter, and output for both channels.
  - After reset: `a`=0, `b`=0, `settled`=1.
  - Reset overrides any in-progress count. A pending change is discarded, not completed.
- Synchroniser: per channel, two-flop chain: sync1 <= raw, then sync2 <= sync1. Only sync2 is used by the rest of the logic.
- Counter rule, per channel, at each edge with `rst` low:
  - If sync2 == out: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: out <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: raw input changes before edge k and is held. Then sync2 changes at edge k+1, and out changes at edge k+1+STABLE_CYCLES.
  - With STABLE_CYCLES=1, out changes at edge k+2 (pure 2-flop sync delay plus one cycle).
- Glitch rejection: if sync2 returns to out before the count completes, cnt clears to 0 and out does not change.
  - A later change restarts counting from 0.
- Channel independence: channels are fully independent.
  - Simultaneous changes on both channels are counted in parallel.
  - Equal-length holds update `a` and `b` on the same edge.
- Counter limits: the counter never wraps. Its maximum reached value is STABLE_CYCLES-1.
- Settled: `settled` = (a_sync2 == a) && (b_sync2 == b).
  - Combinational from registers; no input-to-output combinational path.
  - `settled` deasserts the cycle after sync2 diverges from the output.
  - `settled` reasserts on the edge where the output updates, or where sync2 returns to the output.
- X-handling: none required; raw inputs are assumed driven 0/1 at the synchroniser.

Optional Feature:
- Macro: DEBOUNCE_EDGE_EN
- Defined:
  - Adds output ports `a_rise` (1) and `b_rise` (1), both registered and reset to 0.
  - Each pulses high for exactly one cycle: the cycle in which the corresponding output first reads 1 after reading 0.
  - No pulse on 1->0 transitions or at reset exit.
- Not defined: ports and their logic are absent. All other behaviour is identical.

Test Plan:
All scenarios use STABLE_CYCLES=4.
- Reset: hold `rst`=1 for 3 cycles with a_raw=1, b_raw=1 -> a=0, b=0, settled=1 throughout reset.
- Clean rise: after reset, a_raw 0->1 before edge k and held -> `a` rises at edge k+5; settled=0 from edge k+1 until edge k+5; b stays 0.
- Glitch: b_raw=1 held for 2 cycles, then back to 0 -> `b` never changes; settled returns to 1; counter back to 0.
- Bounce: a_raw toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> exactly one 0->1 transition on `a`, 5 edges after the final 0->1 of a_raw.
- Both inputs with downstream check: a_raw=1 and b_raw=1 on the same cycle -> `a` and `b` rise on the same edge. A downstream AND of `a`,`b` rises on that edge; with DEBOUNCE_EDGE_EN, a_rise and b_rise pulse together for one cycle.
- Reset mid-count: a_raw=1 held; assert `rst` at the 3rd count cycle, deassert -> a=0 at reset. After reset, `a` rises 5 edges after the first post-reset edge (full recount).
